execute_stage: RTL
==================

// Module: execute_stage
// PURPOSE
//  MIPS EX stage plus EX/MEM pipeline register; sits directly upstream of the Memory stage.
//  Performs ALU ops, branch-target add and dest-register select, and registers the results into Memory's inputs.
//  Carries an iterative multiply/divide unit with HI/LO; STALL freezes IF/ID/ID-EX while it runs.
// PARAMETERS
//  DATA_W      32  datapath width; MULDIV_CYCLES = DATA_W busy cycles
//  REG_ADDR_W  5   register-number width
//  CTRL_W      5   M/WB control bundle width, carried opaque to Memory
// PORTS
//  clk              in   1       rising-edge clock
//  RESET_N          in   1       asynchronous, active-low reset
//  FLUSH            in   1       squash current EX instruction
//  READ_DATA_1      in   DATA_W  rs operand (A)
//  READ_DATA_2      in   DATA_W  rt operand; also store data
//  SIGN_EXT_IMM     in   DATA_W  sign-extended imm; [5:0] funct, [10:6] shamt
//  PC_PLUS4         in   DATA_W  PC+4 of this instruction
//  RT, RD           in   5 each  candidate destination registers
//  ALU_OP           in   2       00 add, 01 sub, 10 R-type by funct, 11 slt
//  ALU_SRC          in   1       1: B = SIGN_EXT_IMM, 0: B = READ_DATA_2
//  REG_DST          in   1       1: dest = RD, 0: dest = RT
//  CONTROL_IN       in   CTRL_W  M/WB controls; all-zero = bubble
//  HIT_IN           in   1       cache-hit tag forwarded to Memory
//  STALL            out  1       hold upstream stages and this instruction
//  ALU_RESULT       out  DATA_W  registered ALU result / memory address
//  READ_DATA_2_OUT  out  DATA_W  registered store data
//  BRANCH_TARGET    out  DATA_W  registered PC_PLUS4 + (SIGN_EXT_IMM<<2)
//  ZERO             out  1       registered (ALU result == 0)
//  WRITE_REGISTER   out  5       registered destination register
//  CONTROL_OUT      out  CTRL_W  registered CONTROL_IN, or 0 for a bubble
//  HIT              out  1       registered HIT_IN, or 0 for a bubble
// BEHAVIOUR
//  - Reset: every output and HI/LO = 0, FSM = IDLE, STALL = 0; applies immediately, including mid-operation.
//  - Latency: 1 cycle for ALU ops; results appear after the next rising edge. All sums wrap mod 2^32; overflow is ignored (no traps).
//  - Funct decode: 20/21 add, 22/23 sub, 24 and, 25 or, 26 xor, 27 nor, 2A slt, 2B sltu, 00 sll, 02 srl, 03 sra,
//    10 mfhi, 12 mflo, 18 mult, 19 multu, 1A div, 1B divu.
//  - Any other funct gives result 0; controls still pass through.
//  - FSM IDLE/BUSY/DONE:
//    * IDLE: a mult/div funct with ALU_OP=10 and no FLUSH starts an op. STALL=1 combinationally,
//      operands latch, counter = MULDIV_CYCLES-1, next state BUSY.
//    * BUSY: STALL=1; counter decrements. On the counter==0 edge, HI/LO are written and the state goes to DONE.
//    * DONE: STALL=0. The held instruction retires into EX/MEM with no restart; the next state is IDLE.
//    * Total EX occupancy = MULDIV_CYCLES+2 cycles.
//  - While STALL=1, EX/MEM loads a bubble: CONTROL_OUT=0, HIT=0, WRITE_REGISTER=0; data outputs hold.
//  - Mult: shift-add on magnitudes; the sign is fixed at the end (signed case). HI:LO = 64-bit product.
//  - Div: restoring division. LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
//    Divide by zero gives LO = all-ones, HI = dividend.
//  - mfhi/mflo issued the cycle after DONE see the new HI/LO.
//  - FLUSH: EX/MEM loads a bubble. In BUSY it aborts the op: HI/LO unchanged, next state IDLE, STALL drops the next cycle.
//    FLUSH beats a start in the same cycle.
// CONFIGURATION
//  EXEC_MULDIV_EN defined:   mult/div unit, HI/LO and FSM are built as above.
//  EXEC_MULDIV_EN undefined: no FSM or HI/LO; STALL tied 0.
//    Funct 10/12/18-1B give result 0 with 1-cycle latency; controls still pass through.
// TESTING
//  1 RESET_N=0 mid-BUSY -> all outputs 0, STALL=0 immediately; HI/LO read back 0 after release.
//  2 A=24, B=42, ALU_OP=10, funct 20, REG_DST=1, RD=9, CONTROL_IN=10101 -> next edge ALU_RESULT=66, ZERO=0,
//    WRITE_REGISTER=9, CONTROL_OUT=10101.
//  3 A=B=7, ALU_OP=01, PC_PLUS4=0x100, imm=3 -> ZERO=1, BRANCH_TARGET=0x10C.
//  4 mult A=-3, B=5 -> STALL high 33 cycles, then mflo=0xFFFFFFF1, mfhi=0xFFFFFFFF; bubbles seen during the stall.
//  5 divu 100/7 -> LO=14, HI=2. div -7/2 -> LO=-3, HI=-1. div 5/0 -> LO=0xFFFFFFFF, HI=5.
//  6 FLUSH in cycle 10 of BUSY -> STALL low next cycle, HI/LO unchanged, CONTROL_OUT=0.
//    Build without EXEC_MULDIV_EN: mult -> STALL never high.

Source files
------------

// File: rtl/execute_stage.sv
// execute_stage: MIPS EX stage (ALU, branch-target add, dest select) plus the EX/MEM pipeline register.
// Optional feature macro EXEC_MULDIV_EN: builds the iterative mult/div unit, HI/LO and the IDLE/BUSY/DONE
// FSM that drives STALL. When it is undefined, STALL is tied low and mfhi/mflo/mult/div give result 0.
// Ports: clk, RESET_N (async active-low); FLUSH squashes the EX instruction;
//   READ_DATA_1/READ_DATA_2/SIGN_EXT_IMM/PC_PLUS4/RT/RD/ALU_OP/ALU_SRC/REG_DST/CONTROL_IN/HIT_IN come from ID/EX;
//   STALL holds the upstream stages; ALU_RESULT, READ_DATA_2_OUT, BRANCH_TARGET, ZERO, WRITE_REGISTER,
//   CONTROL_OUT and HIT are the registered EX/MEM outputs feeding the Memory stage.
module execute_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 5
) (
  input  logic                  clk,
  input  logic                  RESET_N,
  input  logic                  FLUSH,
  input  logic [DATA_W-1:0]     READ_DATA_1,
  input  logic [DATA_W-1:0]     READ_DATA_2,
  input  logic [DATA_W-1:0]     SIGN_EXT_IMM,
  input  logic [DATA_W-1:0]     PC_PLUS4,
  input  logic [REG_ADDR_W-1:0] RT,
  input  logic [REG_ADDR_W-1:0] RD,
  input  logic [1:0]            ALU_OP,
  input  logic                  ALU_SRC,
  input  logic                  REG_DST,
  input  logic [CTRL_W-1:0]     CONTROL_IN,
  input  logic                  HIT_IN,
  output logic                  STALL,
  output logic [DATA_W-1:0]     ALU_RESULT,
  output logic [DATA_W-1:0]     READ_DATA_2_OUT,
  output logic [DATA_W-1:0]     BRANCH_TARGET,
  output logic                  ZERO,
  output logic [REG_ADDR_W-1:0] WRITE_REGISTER,
  output logic [CTRL_W-1:0]     CONTROL_OUT,
  output logic                  HIT
);
  logic [DATA_W-1:0] a, b, hi, lo, r_type, alu;
  logic [5:0] funct;
  logic [4:0] shamt;
  assign a = READ_DATA_1;
  assign b = ALU_SRC ? SIGN_EXT_IMM : READ_DATA_2;
  assign funct = SIGN_EXT_IMM[5:0];
  assign shamt = SIGN_EXT_IMM[10:6];
  always_comb begin
    r_type = '0;
    case (funct)
      6'h20, 6'h21: r_type = a + b;
      6'h22, 6'h23: r_type = a - b;
      6'h24:        r_type = a & b;
      6'h25:        r_type = a | b;
      6'h26:        r_type = a ^ b;
      6'h27:        r_type = ~(a | b);
      6'h2A:        r_type = DATA_W'($signed(a) < $signed(b));
      6'h2B:        r_type = DATA_W'(a < b);
      6'h00:        r_type = b << shamt;
      6'h02:        r_type = b >> shamt;
      6'h03:        r_type = DATA_W'($signed(b) >>> shamt);
      6'h10:        r_type = hi;
      6'h12:        r_type = lo;
      default:      r_type = '0;
    endcase
    alu = ALU_OP == 2'b00 ? a + b :
          ALU_OP == 2'b01 ? a - b :
          ALU_OP == 2'b11 ? DATA_W'($signed(a) < $signed(b)) : r_type;
  end
`ifdef EXEC_MULDIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int CW = $clog2(DATA_W);
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] acc_hi, acc_lo, m, dvd, step_hi, step_lo;
  logic [DATA_W:0] sum, sh;
  logic [2*DATA_W-1:0] prod, prod_s;
  logic is_mul, neg_q, neg_r, div0, start, ge, sgn;
  // funct 18..1B; FLUSH beats a start, and nothing starts while reset is held
  assign start = RESET_N && state == IDLE && ALU_OP == 2'b10 && funct[5:2] == 4'b0110 && !FLUSH;
  assign sgn = !funct[0];
  always_comb begin
    STALL = start || state == BUSY;
    state_nxt = state == IDLE ? (start ? BUSY : IDLE) :
                state == BUSY ? (FLUSH ? IDLE : cnt == '0 ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk or negedge RESET_N)
    if (!RESET_N) state <= IDLE;
    else state <= state_nxt;
  // One iteration per BUSY cycle on magnitudes: shift-add multiply keeps the product in acc_hi:acc_lo;
  // restoring divide keeps the partial remainder in acc_hi and shifts quotient bits into acc_lo.
  always_comb begin
    sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : '0);
    sh = {acc_hi, acc_lo[DATA_W-1]};
    ge = sh >= {1'b0, m};
    step_hi = is_mul ? sum[DATA_W:1] : ge ? DATA_W'(sh - {1'b0, m}) : sh[DATA_W-1:0];
    step_lo = is_mul ? {sum[0], acc_lo[DATA_W-1:1]} : {acc_lo[DATA_W-2:0], ge};
    prod = {step_hi, step_lo};
    prod_s = neg_q ? -prod : prod;
  end
  always_ff @(posedge clk or negedge RESET_N)
    if (!RESET_N) begin
      cnt <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      m <= '0;
      dvd <= '0;
      is_mul <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0 <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else if (start) begin
      cnt <= CW'(DATA_W - 1);
      is_mul <= !funct[1];
      neg_q <= sgn && (a[DATA_W-1] ^ b[DATA_W-1]);
      neg_r <= sgn && a[DATA_W-1];
      div0 <= b == '0;
      dvd <= a;
      acc_hi <= '0;
      acc_lo <= sgn && a[DATA_W-1] ? -a : a;
      m <= sgn && b[DATA_W-1] ? -b : b;
    end else if (state == BUSY && !FLUSH) begin
      cnt <= cnt - CW'(1);
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      if (cnt == '0) begin
        hi <= is_mul ? prod_s[2*DATA_W-1:DATA_W] : div0 ? dvd : neg_r ? -step_hi : step_hi;
        lo <= is_mul ? prod_s[DATA_W-1:0] : div0 ? '1 : neg_q ? -step_lo : step_lo;
      end
    end
`else
  assign STALL = 1'b0;
  assign hi = '0;
  assign lo = '0;
`endif
  // A stalled or flushed slot enters Memory as a bubble; data fields simply hold.
  always_ff @(posedge clk or negedge RESET_N)
    if (!RESET_N) begin
      ALU_RESULT <= '0;
      READ_DATA_2_OUT <= '0;
      BRANCH_TARGET <= '0;
      ZERO <= 1'b0;
      WRITE_REGISTER <= '0;
      CONTROL_OUT <= '0;
      HIT <= 1'b0;
    end else if (STALL || FLUSH) begin
      WRITE_REGISTER <= '0;
      CONTROL_OUT <= '0;
      HIT <= 1'b0;
    end else begin
      ALU_RESULT <= alu;
      READ_DATA_2_OUT <= READ_DATA_2;
      BRANCH_TARGET <= PC_PLUS4 + (SIGN_EXT_IMM << 2);
      ZERO <= alu == '0;
      WRITE_REGISTER <= REG_DST ? RD : RT;
      CONTROL_OUT <= CONTROL_IN;
      HIT <= HIT_IN;
    end
endmodule
